dmem_responder: RTL

Data-memory responder for the MIPS datapath's load/store port. It accepts one request at a time from the processor's memory stage over a valid/ready handshake, inserts a programmable number of wait states, and then performs the access. Accesses are byte, halfword or word, with byte-lane write masking and sign/zero-extended loads. It replaces the ideal single-cycle data memory so that lb/lh/lbu/lhu/sb/sh/lw/sw can be exercised against a latency-bearing slave.

---
 rtl/dmem_pkg.sv | 29 ++
 rtl/dmem_lane_align.sv | 50 +++++
 rtl/dmem_responder.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory responder: access sizes, FSM states,
// and the alignment/legality check used when an access is performed.
// Pure definitions; no timing or flow control of its own.
package dmem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_RSVD = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    // An access is illegal when misaligned for its size or when the size is reserved.
    function automatic logic access_error(input logic [1:0] size, input logic [1:0] addr_lo);
        logic err;
        case (size)
            SIZE_BYTE: err = 1'b0;
            SIZE_HALF: err = addr_lo[0];
            SIZE_WORD: err = |addr_lo;
            default:   err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store byte-enables/replicated write word, and load extraction with sign/zero extension.
// Latency: purely combinational.
// Backpressure: none; it has no handshake.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_addr_lo,
    input  logic        i_unsigned,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rword,
    output logic [3:0]  o_be,
    output logic [31:0] o_wword,
    output logic [31:0] o_rdata
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_sext;

    assign w_byte = i_rword[{i_addr_lo, 3'b000} +: 8];
    assign w_half = i_addr_lo[1] ? i_rword[31:16] : i_rword[15:0];
    assign w_sext = ~i_unsigned;

    // Store data is replicated across lanes so the byte-enable alone selects the target lane(s).
    always_comb begin
        o_be    = 4'b0000;
        o_wword = i_wdata;
        o_rdata = i_rword;
        case (i_size)
            SIZE_BYTE: begin
                o_be    = 4'b0001 << i_addr_lo;
                o_wword = {4{i_wdata[7:0]}};
                o_rdata = {{24{w_sext & w_byte[7]}}, w_byte};
            end
            SIZE_HALF: begin
                o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wword = {2{i_wdata[15:0]}};
                o_rdata = {{16{w_sext & w_half[15]}}, w_half};
            end
            SIZE_WORD: begin
                o_be    = 4'b1111;
            end
            default: begin
                o_rdata = 32'h0;
            end
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory slave for the load/store port: one request at a time, WAIT_STATES of delay, then access.
// Latency: RespValid pulses WAIT_STATES+1 cycles after the accepting edge; one request per WAIT_STATES+2 cycles.
// Backpressure: ReqReady is high only in IDLE; responses cannot be stalled. Optional counters: DMEM_STATS_EN.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 2
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic        ReqWrite,
    input  logic [1:0]  ReqSize,
    input  logic        ReqUnsigned,
    input  logic [31:0] ReqAddress,
    input  logic [31:0] ReqWriteData,
    output logic        RespValid,
    output logic [31:0] RespReadData,
    output logic        RespError
`ifdef DMEM_STATS_EN
    ,
    output logic [15:0] StatReads,
    output logic [15:0] StatWrites,
    output logic [15:0] StatErrors
`endif
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);

    state_t          r_state;
    state_t          w_next;
    logic [CW-1:0]   r_cnt;
    logic            r_write;
    logic            r_unsigned;
    logic [1:0]      r_size;
    logic [1:0]      r_lo;
    logic [AW-1:0]   r_idx;
    logic [31:0]     r_wdata;
    logic [31:0]     r_rdata;
    logic            r_err;
    logic [31:0]     r_mem [DEPTH_WORDS];

    logic            w_accept;
    logic            w_access;
    logic            w_from_in;
    logic            w_acc_write;
    logic            w_acc_unsigned;
    logic [1:0]      w_acc_size;
    logic [1:0]      w_acc_lo;
    logic [AW-1:0]   w_acc_idx;
    logic [31:0]     w_acc_wdata;
    logic            w_acc_err;
    logic [31:0]     w_rword;
    logic [3:0]      w_be;
    logic [31:0]     w_wword;
    logic [31:0]     w_ld_data;
    logic            w_unused;

    assign w_accept = ReqValid && (r_state == IDLE);
    // With zero wait states the access happens on the accepting edge itself, before the latch is loaded.
    assign w_access = ((r_state == BUSY) && (r_cnt == CNT_LAST)) ||
                      (w_accept && (WAIT_STATES == 0));

    assign w_from_in      = (r_state == IDLE);
    assign w_acc_write    = w_from_in ? ReqWrite          : r_write;
    assign w_acc_unsigned = w_from_in ? ReqUnsigned       : r_unsigned;
    assign w_acc_size     = w_from_in ? ReqSize           : r_size;
    assign w_acc_lo       = w_from_in ? ReqAddress[1:0]   : r_lo;
    assign w_acc_idx      = w_from_in ? ReqAddress[AW+1:2] : r_idx;
    assign w_acc_wdata    = w_from_in ? ReqWriteData      : r_wdata;
    assign w_acc_err      = access_error(w_acc_size, w_acc_lo);
    assign w_rword        = r_mem[w_acc_idx];

    // Address bits above the array index alias onto the same words.
    assign w_unused = ^ReqAddress[31:AW+2];

    dmem_lane_align u_align (
        .i_size     (w_acc_size),
        .i_addr_lo  (w_acc_lo),
        .i_unsigned (w_acc_unsigned),
        .i_wdata    (w_acc_wdata),
        .i_rword    (w_rword),
        .o_be       (w_be),
        .o_wword    (w_wword),
        .o_rdata    (w_ld_data)
    );

    // FSM state register.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    // FSM next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = (WAIT_STATES == 0) ? RESP : BUSY;
            BUSY:    if (r_cnt == CNT_LAST) w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Wait-state counter and request latch.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_cnt      <= '0;
            r_write    <= 1'b0;
            r_unsigned <= 1'b0;
            r_size     <= 2'b00;
            r_lo       <= 2'b00;
            r_idx      <= '0;
            r_wdata    <= 32'h0;
        end else begin
            if (r_state == BUSY) r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
            else                 r_cnt <= '0;
            if (w_accept) begin
                r_write    <= ReqWrite;
                r_unsigned <= ReqUnsigned;
                r_size     <= ReqSize;
                r_lo       <= ReqAddress[1:0];
                r_idx      <= ReqAddress[AW+1:2];
                r_wdata    <= ReqWriteData;
            end
        end
    end

    // Response data/error captured at the access edge and held until the next access.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_rdata <= 32'h0;
            r_err   <= 1'b0;
        end else if (w_access) begin
            r_err   <= w_acc_err;
            r_rdata <= (w_acc_err || w_acc_write) ? 32'h0 : w_ld_data;
        end
    end

    // Masked store into the array; contents survive reset, and reset state blocks a pending write.
    always_ff @(posedge Clk) begin
        if (w_access && w_acc_write && !w_acc_err) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) r_mem[w_acc_idx][8*i +: 8] <= w_wword[8*i +: 8];
            end
        end
    end

    assign ReqReady     = (r_state == IDLE);
    assign RespValid    = (r_state == RESP);
    assign RespReadData = r_rdata;
    assign RespError    = r_err;

`ifdef DMEM_STATS_EN
    logic [15:0] r_stat_rd;
    logic [15:0] r_stat_wr;
    logic [15:0] r_stat_er;

    // Saturating per-class completion counters; an errored access counts only as an error.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_stat_rd <= 16'h0;
            r_stat_wr <= 16'h0;
            r_stat_er <= 16'h0;
        end else if (r_state == RESP) begin
            if (r_err) begin
                if (r_stat_er != 16'hFFFF) r_stat_er <= r_stat_er + 16'h1;
            end else if (r_write) begin
                if (r_stat_wr != 16'hFFFF) r_stat_wr <= r_stat_wr + 16'h1;
            end else begin
                if (r_stat_rd != 16'hFFFF) r_stat_rd <= r_stat_rd + 16'h1;
            end
        end
    end

    assign StatReads  = r_stat_rd;
    assign StatWrites = r_stat_wr;
    assign StatErrors = r_stat_er;
`endif

endmodule
